// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised serial input, centre-sampled 8N1-style frames,
// holding register with valid/ack handshake, frame-error pulse and sticky overrun flag.
module uart_rx #(
  parameter int clks_per_bit = 104,
  parameter int BITS         = 8
) (
  input  logic            i_wb_clk,
  input  logic            i_wb_rst,
  input  logic            i_rx,
  input  logic            i_rx_ack,
  output logic [BITS-1:0] o_rx_dat,
  output logic            o_rx_valid,
  output logic            o_frame_err,
  output logic            o_overrun,
  output logic            o_busy
);

  localparam int CW = $clog2(clks_per_bit);
  localparam int IW = $clog2(BITS) + 1;
  localparam logic [CW-1:0] HALF_C = CW'((clks_per_bit - 1) / 2);
  localparam logic [CW-1:0] LAST_C = CW'(clks_per_bit - 1);
  localparam logic [IW-1:0] LAST_IDX_C = IW'(BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     clk_cnt_q;
  logic [IW-1:0]     idx_q;
  logic [BITS-1:0]   shift_q;
  logic [BITS-1:0]   dat_q;
  logic              valid_q;
  logic              frame_err_q;
  logic              overrun_q;
  logic              busy_q;
  logic              sync1_q;
  logic              sync2_q;
  logic              rx_s;

  assign rx_s        = sync2_q;
  assign o_rx_dat    = dat_q;
  assign o_rx_valid  = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = busy_q;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst) begin
    if (!i_wb_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
    end
  end

  // Frame FSM with registered handshake/status outputs; later assignments win over the ack clear.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst) begin
    if (!i_wb_rst) begin
      state_q     <= IDLE;
      clk_cnt_q   <= {CW{1'b0}};
      idx_q       <= {IW{1'b0}};
      shift_q     <= {BITS{1'b0}};
      dat_q       <= {BITS{1'b0}};
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (i_rx_ack) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          clk_cnt_q <= {CW{1'b0}};
          idx_q     <= {IW{1'b0}};
          if (!rx_s) begin
            state_q <= START;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        START: begin
          if (clk_cnt_q == HALF_C) begin
            clk_cnt_q <= {CW{1'b0}};
            if (!rx_s) begin
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt_q == LAST_C) begin
            clk_cnt_q <= {CW{1'b0}};
            shift_q   <= {rx_s, shift_q[BITS-1:1]};
            idx_q     <= idx_q + IW'(1);
            if (idx_q == LAST_IDX_C) begin
              state_q <= STOP;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (clk_cnt_q == LAST_C) begin
            clk_cnt_q <= {CW{1'b0}};
            idx_q     <= {IW{1'b0}};
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            if (rx_s) begin
              dat_q     <= shift_q;
              valid_q   <= 1'b1;
              overrun_q <= i_rx_ack ? 1'b0 : (overrun_q | valid_q);
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          clk_cnt_q <= {CW{1'b0}};
          idx_q     <= {IW{1'b0}};
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: senders queue expected words and arrival cycles,
// a negedge monitor pops and compares each delivered word.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int NB  = 8;
  // Edges from driving the start bit to the edge that raises o_rx_valid.
  localparam int LAT = 3 + 1 + (CPB - 1) / 2 + (NB + 1) * CPB;

  typedef struct {
    logic [7:0] dat;
    int         cyc;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          rx;
  logic          ack;
  logic [NB-1:0] rx_dat;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int   checks;
  int   errors;
  int   cyc;
  int   fe_hi;
  int   fe_rise;
  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_d;
  logic prev_valid;
  logic [NB-1:0] prev_dat;
  logic prev_fe;

  uart_rx #(.clks_per_bit(CPB), .BITS(NB)) dut (
    .i_wb_clk   (clk),
    .i_wb_rst   (rst_n),
    .i_rx       (rx),
    .i_rx_ack   (ack),
    .o_rx_dat   (rx_dat),
    .o_rx_valid (rx_valid),
    .o_frame_err(frame_err),
    .o_overrun  (overrun),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a delivery is valid rising or the held word changing while valid.
  always @(negedge clk) begin
    if (rx_valid && (!prev_valid || rx_dat != prev_dat)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", rx_dat);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rx_dat", 32'(rx_dat), 32'(mon_e.dat));
        mon_d = cyc - mon_e.cyc;
        checks++;
        if (mon_d < -1 || mon_d > 1) begin
          errors++;
          $display("FAIL latency: got cycle %0d expected %0d +-1", cyc, mon_e.cyc);
        end
      end
    end
    if (frame_err) fe_hi <= fe_hi + 1;
    if (frame_err && !prev_fe) fe_rise <= fe_rise + 1;
    prev_valid <= rx_valid;
    prev_dat   <= rx_dat;
    prev_fe    <= frame_err;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic good);
    exp_t e;
    @(negedge clk);
    rx = 1'b0;
    if (good) begin
      e.dat = b;
      e.cyc = cyc + LAT;
      exp_q.push_back(e);
    end
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dat"},   32'(rx_dat),    32'd0);
    chk({tag, "_valid"}, 32'(rx_valid),  32'd0);
    chk({tag, "_ferr"},  32'(frame_err), 32'd0);
    chk({tag, "_ovr"},   32'(overrun),   32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  int fe_hi0;
  int fe_rise0;

  initial begin
    checks = 0; errors = 0; cyc = 0; fe_hi = 0; fe_rise = 0;
    prev_valid = 1'b0; prev_dat = '0; prev_fe = 1'b0;
    rst_n = 1'b0; rx = 1'b1; ack = 1'b0;
    repeat (5) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Idle line
    repeat (500) @(negedge clk);
    chk("idle_valid", 32'(rx_valid), 32'd0);
    chk("idle_busy",  32'(busy),     32'd0);
    chk("idle_ferr_count", 32'(fe_hi), 32'd0);

    // Single good word then ack
    send_frame(8'hA5, 1'b1, 1'b1);
    chk("a5_valid", 32'(rx_valid), 32'd1);
    chk("a5_dat",   32'(rx_dat),   32'hA5);
    chk("a5_ovr",   32'(overrun),  32'd0);
    pulse_ack();
    chk("a5_ack_valid", 32'(rx_valid), 32'd0);

    // Back-to-back without ack: overrun
    send_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'h81, 1'b1, 1'b1);
    chk("ovr_dat",   32'(rx_dat),   32'h81);
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    chk("ovr_flag",  32'(overrun),  32'd1);
    pulse_ack();
    chk("ovr_ack_valid", 32'(rx_valid), 32'd0);
    chk("ovr_ack_flag",  32'(overrun),  32'd0);

    // Framing error: stop bit low
    fe_hi0 = fe_hi; fe_rise0 = fe_rise;
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    chk("fe_cycles", 32'(fe_hi - fe_hi0),     32'd1);
    chk("fe_pulses", 32'(fe_rise - fe_rise0), 32'd1);
    chk("fe_valid",  32'(rx_valid), 32'd0);
    chk("fe_dat",    32'(rx_dat),   32'h81);

    // Short glitch is rejected in START
    fe_hi0 = fe_hi;
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch_busy_hi", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_busy_lo", 32'(busy),  32'd0);
    chk("glitch_valid",   32'(rx_valid), 32'd0);
    chk("glitch_ferr",    32'(fe_hi - fe_hi0), 32'd0);
    send_frame(8'h00, 1'b1, 1'b1);
    chk("zero_dat",   32'(rx_dat),   32'h00);
    chk("zero_valid", 32'(rx_valid), 32'd1);

    // Reset in the middle of data bit 4 of 0xFF, word 0x00 left unacked
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    chk("post_rst_valid", 32'(rx_valid), 32'd0);
    send_frame(8'h12, 1'b1, 1'b1);
    chk("x12_dat",   32'(rx_dat),   32'h12);
    chk("x12_valid", 32'(rx_valid), 32'd1);
    pulse_ack();
    chk("x12_ack_valid", 32'(rx_valid), 32'd0);

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver paired with the UART transmitter in the service block.
- Consumes the idle-high serial line (start bit, BITS data bits LSB first, one stop bit) at clks_per_bit clocks per bit.
- Delivers each received byte through a holding register with a valid/ack handshake to the Wishbone-side logic.
- Flags framing errors and overruns.

Parameters:
- clks_per_bit, 104, system clocks per serial bit; minimum 4.
- BITS, 8, data bits per frame; range 5..8.

Ports:
- i_wb_clk  input  1  system clock; all logic on rising edge.
- i_wb_rst  input  1  asynchronous, active-low reset.
- i_rx  input  1  asynchronous serial line; idle high.
- i_rx_ack  input  1  consumer pulse; clears o_rx_valid.
- o_rx_dat  output  BITS  last good received word.
- o_rx_valid  output  1  level; o_rx_dat holds an unconsumed word.
- o_frame_err  output  1  one-cycle pulse; stop bit sampled low.
- o_overrun  output  1  sticky; good word arrived while o_rx_valid=1. Cleared by i_rx_ack or reset.
- o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (i_wb_rst=0, async):
  - State IDLE; counters 0.
  - Both synchroniser flops = 1.
  - Outputs: o_rx_dat=0, o_rx_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
  - Reset mid-frame abandons the frame; nothing is delivered.
- Input sync:
  - i_rx passes through a 2-flop synchroniser; rx_s is the second flop.
  - All decisions use rx_s only.
- Counters:
  - Bit counter clk_cnt is $clog2(clks_per_bit) bits wide.
  - Data index is $clog2(BITS)+1 bits wide.
  - H = (clks_per_bit-1)/2, integer division.
- FSM (4 states):
  - IDLE:
    - clk_cnt=0, index=0.
    - rx_s=0 → START; otherwise stay.
  - START:
    - clk_cnt increments each cycle.
    - At clk_cnt==H, sample rx_s.
    - If 0: clk_cnt=0, go to DATA.
    - If 1: glitch; go to IDLE with no output activity.
  - DATA:
    - clk_cnt counts 0..clks_per_bit-1.
    - At clks_per_bit-1 (bit centre), shift rx_s into the MSB of the shift register (right shift, LSB first), clk_cnt=0, index+1.
    - After the BITS-th sample → STOP.
  - STOP:
    - Count to clks_per_bit-1, then sample rx_s and go to IDLE.
    - Return to IDLE happens at the stop-bit centre, so back-to-back frames are received.
- Stop sample = 1 (good frame):
  - On the next edge, o_rx_dat = shift register and o_rx_valid = 1.
  - If o_rx_valid was already 1 and no ack is in the same cycle: o_rx_dat is overwritten with the newest word and o_overrun = 1.
- Stop sample = 0 (framing error):
  - o_frame_err pulses for exactly one cycle.
  - o_rx_dat, o_rx_valid and o_overrun are unchanged; the word is discarded.
  - The FSM returns to IDLE. If the line stays low it re-enters START, and a break condition produces repeated frame errors, one per frame length.
- i_rx_ack:
  - Clears o_rx_valid and o_overrun on the next edge.
  - Ack with o_rx_valid=0 has no effect.
- Simultaneous ack and new good word in the same cycle: o_rx_valid stays 1, o_rx_dat = new word, o_overrun = 0.
- Latency:
  - Let T0 be the first cycle with rx_s=0.
  - Data bit k is sampled at T0 + 1 + H + (k+1)*clks_per_bit.
  - o_rx_valid rises at T0 + 2 + H + (BITS+1)*clks_per_bit.
  - i_rx-to-rx_s adds 2 cycles.
  - Bench tolerance: ±1 cycle.
- Tolerates ±3% baud mismatch: centre sampling, no mid-frame resync.

Test Plan (clks_per_bit=16, BITS=8):
- Reset then idle-high line for 500 cycles → o_rx_valid=0, o_busy=0, o_frame_err never pulses.
- Send 0xA5 with correct stop bit → o_rx_dat=0xA5 and o_rx_valid=1 within latency ±1. Ack → o_rx_valid=0 the next cycle.
- Send 0x3C then 0x81 back-to-back without ack → o_rx_dat=0x81, o_rx_valid=1, o_overrun=1. Ack clears both flags.
- Send 0x55 with stop bit held low → exactly one o_frame_err pulse; o_rx_valid stays 0; o_rx_dat unchanged.
- 5-cycle low glitch on an idle line → FSM returns to IDLE from START, no valid, no frame error. Then send 0x00 → o_rx_dat=0x00.
- Assert reset at data bit 4 of 0xFF, release, then send 0x12 → only 0x12 is delivered; all outputs are 0 during reset.
